// File: rtl/mrv32_wb_pipe.sv
// Writeback/retire stage: captures EX/MEM results, extracts loads, selects wdata,
// drives the register file write port and commit pulse, and counts retired instructions.
module mrv32_wb_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned INSTRET_W = 64,
  parameter bit          SKID      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_reg_wen,
  input  logic [4:0]           in_rd,
  input  logic [2:0]           in_sel,
  input  logic                 in_take_branch,
  input  logic [XLEN-1:0]      in_target,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_alu,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [XLEN-1:0]      in_load_data,
  input  logic [2:0]           in_ld_funct3,
  input  logic [1:0]           in_ld_off,
  input  logic                 wb_stall,
  output logic                 rf_wen,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 instr_accept,
  output logic [XLEN-1:0]      pc_next,
  output logic                 ld_misalign,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [XLEN-1:0]      fwd_data,
  output logic [INSTRET_W-1:0] instret
);

  // wr already folds in rd!=0, legal sel and alignment so commit logic stays trivial.
  typedef struct packed {
    logic            wr;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] pc_next;
    logic            mis;
  } entry_t;

  entry_t                h_q, h_d, k_q, k_d, new_e;
  logic                  h_valid_q, h_valid_d, k_valid_q, k_valid_d;
  logic [INSTRET_W-1:0]  instret_q;
  logic                  commit, push;
  logic [XLEN-1:0]       ld_shift, ld_val, sel_wdata;
  logic                  ld_mis, sel_legal, sel_mis;

  assign ld_shift = in_load_data >> {in_ld_off, 3'b000};

  always_comb begin
    ld_val = '0;
    ld_mis = 1'b0;
    case (in_ld_funct3)
      3'b000: ld_val = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      3'b100: ld_val = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
      3'b001: begin
        ld_val = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
        ld_mis = in_ld_off[0];
      end
      3'b101: begin
        ld_val = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
        ld_mis = in_ld_off[0];
      end
      3'b010: begin
        ld_val = ld_shift;
        ld_mis = |in_ld_off;
      end
      default: ld_mis = 1'b1;
    endcase
  end

  always_comb begin
    sel_wdata = '0;
    sel_legal = 1'b1;
    sel_mis   = 1'b0;
    case (in_sel)
      3'd0: sel_wdata = in_alu;
      3'd1: begin
        sel_wdata = ld_val;
        sel_mis   = ld_mis;
      end
      3'd2: sel_wdata = in_imm;
      3'd3: sel_wdata = in_pc + in_imm;
      3'd4: sel_wdata = in_pc + XLEN'(4);
      default: sel_legal = 1'b0;
    endcase
  end

  always_comb begin
    new_e.wr      = in_reg_wen & sel_legal & (in_rd != 5'd0) & ~sel_mis;
    new_e.rd      = in_rd;
    new_e.wdata   = sel_wdata;
    new_e.pc_next = in_take_branch ? (in_target & ~XLEN'(1)) : in_pc + XLEN'(4);
    new_e.mis     = sel_mis;
  end

  assign commit   = h_valid_q & ~wb_stall;
  assign in_ready = SKID ? ~k_valid_q : (~h_valid_q | commit);
  assign push     = in_valid & in_ready;

  // Two-entry FIFO: retire first, then the arrival lands in the first free slot.
  always_comb begin
    h_valid_d = h_valid_q;
    k_valid_d = k_valid_q;
    h_d       = h_q;
    k_d       = k_q;
    if (commit) begin
      h_valid_d = k_valid_q;
      h_d       = k_q;
      k_valid_d = 1'b0;
    end
    if (push) begin
      if (!h_valid_d) begin
        h_valid_d = 1'b1;
        h_d       = new_e;
      end else begin
        k_valid_d = 1'b1;
        k_d       = new_e;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
      h_q       <= '0;
      k_q       <= '0;
      instret_q <= '0;
    end else begin
      h_valid_q <= h_valid_d;
      k_valid_q <= k_valid_d;
      h_q       <= h_d;
      k_q       <= k_d;
      if (commit) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign instr_accept = commit;
  assign rf_wen       = commit & h_q.wr;
  assign rf_waddr     = h_q.rd;
  assign rf_wdata     = h_q.wdata;
  assign pc_next      = h_q.pc_next;
  assign ld_misalign  = commit & h_q.mis;
  assign fwd_valid    = h_valid_q & h_q.wr;
  assign fwd_rd       = h_q.rd;
  assign fwd_data     = h_q.wdata;
  assign instret      = instret_q;

endmodule

// File: tb/tb_mrv32_wb_pipe.sv
// Bench for mrv32_wb_pipe: vector table through a scoreboard, plus stall/skid and
// mid-operation reset sequences.
module tb_mrv32_wb_pipe;

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_reg_wen, in_take_branch, wb_stall;
  logic [4:0]  in_rd;
  logic [2:0]  in_sel, in_ld_funct3;
  logic [1:0]  in_ld_off;
  logic [31:0] in_target, in_pc, in_alu, in_imm, in_load_data;
  logic        rf_wen, instr_accept, ld_misalign, fwd_valid;
  logic [4:0]  rf_waddr, fwd_rd;
  logic [31:0] rf_wdata, pc_next, fwd_data;
  logic [63:0] instret;

  mrv32_wb_pipe #(.XLEN(32), .INSTRET_W(64), .SKID(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_wen(in_reg_wen), .in_rd(in_rd), .in_sel(in_sel),
    .in_take_branch(in_take_branch), .in_target(in_target), .in_pc(in_pc),
    .in_alu(in_alu), .in_imm(in_imm), .in_load_data(in_load_data),
    .in_ld_funct3(in_ld_funct3), .in_ld_off(in_ld_off), .wb_stall(wb_stall),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .instr_accept(instr_accept), .pc_next(pc_next), .ld_misalign(ld_misalign),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic        wen;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] pc, alu, imm, word;
    logic        take;
    logic [31:0] target;
    logic [31:0] e_wdata;
    logic        e_wen;
    logic [31:0] e_pcn;
    logic        e_mis;
    logic        e_chkwd;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] pcn;
    logic        mis;
    logic        chkwd;
  } exp_t;

  vec_t  tbl [18];
  exp_t  sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  longint exp_instret = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input vec_t v);
    int   guard;
    bit   done;
    exp_t e;
    in_sel = v.sel; in_reg_wen = v.wen; in_rd = v.rd; in_ld_funct3 = v.f3;
    in_ld_off = v.off; in_pc = v.pc; in_alu = v.alu; in_imm = v.imm;
    in_load_data = v.word; in_take_branch = v.take; in_target = v.target;
    in_valid = 1'b1;
    done = 1'b0;
    guard = 0;
    while (!done && guard < 50) begin
      @(negedge clk);
      if (in_ready) begin
        e.rd = v.rd; e.wen = v.e_wen; e.wdata = v.e_wdata; e.pcn = v.e_pcn;
        e.mis = v.e_mis; e.chkwd = v.e_chkwd;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  vec_t a, b, c;

  initial begin
    //        sel wen rd f3 off pc            alu           imm           word          tk tgt           e_wdata       ewen e_pcn        mis chk
    tbl[0]  = '{3'd2, 1, 5, 0, 0, 32'h1000,     0,            32'h12345000, 0,            0, 0,            32'h12345000, 1, 32'h1004,     0, 1};
    tbl[1]  = '{3'd1, 1, 6, 0, 3, 32'h1004,     0,            0,            32'h80FF0000, 0, 0,            32'hFFFFFF80, 1, 32'h1008,     0, 1};
    tbl[2]  = '{3'd1, 1, 6, 4, 3, 32'h1008,     0,            0,            32'h80FF0000, 0, 0,            32'h00000080, 1, 32'h100C,     0, 1};
    tbl[3]  = '{3'd1, 1, 6, 1, 2, 32'h100C,     0,            0,            32'h80FF0000, 0, 0,            32'hFFFF80FF, 1, 32'h1010,     0, 1};
    tbl[4]  = '{3'd1, 1, 6, 5, 2, 32'h1010,     0,            0,            32'h80FF0000, 0, 0,            32'h000080FF, 1, 32'h1014,     0, 1};
    tbl[5]  = '{3'd1, 1, 7, 2, 2, 32'h1014,     0,            0,            32'h80FF0000, 0, 0,            0,            0, 32'h1018,     1, 0};
    tbl[6]  = '{3'd4, 1, 1, 0, 0, 32'h100,      0,            0,            0,            1, 32'h201,      32'h104,      1, 32'h200,      0, 1};
    tbl[7]  = '{3'd4, 1, 0, 0, 0, 32'h100,      0,            0,            0,            1, 32'h201,      32'h104,      0, 32'h200,      0, 1};
    tbl[8]  = '{3'd0, 1, 10, 0, 0, 32'h200,     32'hDEADBEEF, 0,            0,            0, 0,            32'hDEADBEEF, 1, 32'h204,      0, 1};
    tbl[9]  = '{3'd3, 1, 11, 0, 0, 32'h2000,    0,            32'hFFFFF000, 0,            0, 0,            32'h1000,     1, 32'h2004,     0, 1};
    tbl[10] = '{3'd5, 1, 3, 0, 0, 32'h3000,     32'h1234,     32'h5678,     0,            0, 0,            0,            0, 32'h3004,     0, 1};
    tbl[11] = '{3'd1, 1, 8, 2, 0, 32'h3004,     0,            0,            32'hCAFEBABE, 0, 0,            32'hCAFEBABE, 1, 32'h3008,     0, 1};
    tbl[12] = '{3'd1, 1, 9, 0, 1, 32'h3008,     0,            0,            32'h00007F00, 0, 0,            32'h0000007F, 1, 32'h300C,     0, 1};
    tbl[13] = '{3'd1, 1, 9, 3, 0, 32'h300C,     0,            0,            32'h11223344, 0, 0,            0,            0, 32'h3010,     1, 0};
    tbl[14] = '{3'd1, 1, 9, 1, 1, 32'h3010,     0,            0,            32'h11223344, 0, 0,            0,            0, 32'h3014,     1, 0};
    tbl[15] = '{3'd4, 1, 12, 0, 0, 32'hFFFFFFFC, 0,           0,            0,            0, 0,            32'h0,        1, 32'h0,        0, 1};
    tbl[16] = '{3'd0, 0, 4, 0, 0, 32'h4000,     32'h55AA55AA, 0,            0,            0, 0,            32'h55AA55AA, 0, 32'h4004,     0, 1};
    tbl[17] = '{3'd2, 1, 13, 0, 0, 32'h4004,    0,            32'hABCDE000, 0,            1, 32'h80000003, 32'hABCDE000, 1, 32'h80000002, 0, 1};

    rst_n = 1'b1; in_valid = 1'b0; wb_stall = 1'b0;
    in_sel = '0; in_reg_wen = 1'b0; in_rd = '0; in_ld_funct3 = '0; in_ld_off = '0;
    in_pc = '0; in_alu = '0; in_imm = '0; in_load_data = '0; in_take_branch = 1'b0;
    in_target = '0;

    // Commit monitor / scoreboard checker
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
          sb.delete();
          exp_instret = 0;
        end else if (!instr_accept) begin
          chk("rf_wen_idle", 64'(rf_wen), 64'd0);
        end else if (sb.size() == 0) begin
          chk("unexpected_commit", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rf_wen", 64'(rf_wen), 64'(e.wen));
          chk("rf_waddr", 64'(rf_waddr), 64'(e.rd));
          if (e.chkwd) chk("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
          chk("pc_next", 64'(pc_next), 64'(e.pcn));
          chk("ld_misalign", 64'(ld_misalign), 64'(e.mis));
          chk("fwd_valid", 64'(fwd_valid), 64'(e.wen));
          if (e.wen) chk("fwd_data", 64'(fwd_data), 64'(e.wdata));
          chk("instret", instret, 64'(exp_instret));
          exp_instret++;
        end
      end
    join_none

    #3 rst_n = 1'b0;
    #2;
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_accept", 64'(instr_accept), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_misalign", 64'(ld_misalign), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Back-to-back vector table
    for (int i = 0; i < 18; i++) send(tbl[i]);
    drain();
    chk("instret_table", instret, 64'd18);

    // Skid: stall while two arrive, third waits on in_ready
    a = tbl[8]; a.rd = 5'd20; a.alu = 32'hA0A0A0A0; a.e_wdata = 32'hA0A0A0A0;
    b = tbl[8]; b.rd = 5'd21; b.alu = 32'hB1B1B1B1; b.e_wdata = 32'hB1B1B1B1;
    c = tbl[8]; c.rd = 5'd22; c.alu = 32'hC2C2C2C2; c.e_wdata = 32'hC2C2C2C2;
    wb_stall = 1'b1;
    send(a);
    send(b);
    @(negedge clk);
    chk("skid_in_ready_low", 64'(in_ready), 64'd0);
    chk("stall_fwd_valid", 64'(fwd_valid), 64'd1);
    chk("stall_fwd_rd", 64'(fwd_rd), 64'd20);
    chk("stall_fwd_data", 64'(fwd_data), 64'hA0A0A0A0);
    fork
      send(c);
      begin
        @(posedge clk); #1 wb_stall = 1'b0;
      end
    join
    drain();
    chk("instret_skid", instret, 64'd21);

    // Reset with two entries pending
    wb_stall = 1'b1;
    send(tbl[0]);
    send(tbl[1]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("mid_rst_accept", 64'(instr_accept), 64'd0);
    chk("mid_rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("mid_rst_instret", instret, 64'd0);
    wb_stall = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    send(tbl[6]);
    drain();
    chk("instret_after_rst", instret, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
